da_tap_window: RTL and testbench

Parametrised tap delay line and bit-serial window generator for the distributed-arithmetic FIR datapath. Each accepted input sample shifts into a TAPS-deep delay line, and the new window loads into per-tap serialisers. The serialisers emit one bit-plane per cycle, MSB first, as grouped LUT addresses for the downstream DA accumulator. Data moves over valid/ready handshakes on both sides, in a single clock domain, with a synchronous flush and fill tracking.

---
 rtl/da_pkg.sv | 18 +
 rtl/da_bit_serializer.sv | 30 +++
 rtl/da_tap_window.sv | 109 ++++++++++
 tb/tb_da_tap_window.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared constants, state type and width helper for the DA tap window.
package da_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned TAPS_DEF   = 64;
    localparam int unsigned GROUP_DEF  = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/da_bit_serializer.sv
// One tap's MSB-first parallel-in/serial-out register; load wins over shift.
module da_bit_serializer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (load) begin
            sr <= d;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/da_tap_window.sv
// Tap delay line plus bit-plane serialisers feeding a DA accumulator,
// with valid/ready on both sides, synchronous flush and fill tracking.
module da_tap_window
    import da_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAPS   = TAPS_DEF,
    parameter int unsigned GROUP  = GROUP_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [TAPS-1:0]   addr_out,
    output logic              addr_first,
    output logic              addr_last,
    output logic              window_full,
    output logic              busy
);

    localparam int unsigned NGROUP = TAPS / GROUP;
    localparam int unsigned BW     = cnt_w(DATA_W);
    localparam int unsigned FW     = cnt_w(TAPS + 1);

    if (NGROUP * GROUP != TAPS) begin : g_bad_group
        $error("da_tap_window: TAPS must be a multiple of GROUP");
    end
    if (DATA_W < 2) begin : g_bad_width
        $error("da_tap_window: DATA_W must be at least 2");
    end

    state_t            state;
    logic [BW-1:0]     bcnt;
    logic [FW-1:0]     fill;
    logic [DATA_W-1:0] tap      [TAPS];
    logic [DATA_W-1:0] tap_next [TAPS];
    logic [TAPS-1:0]   msb;

    logic accept;
    logic plane_hs;
    logic last_plane;

    assign last_plane = (bcnt == '0);
    assign plane_hs   = (state == SHIFT) && addr_ready;
    // addr_ready reaches s_ready combinationally so windows run back to back.
    assign s_ready    = !flush && ((state == IDLE) || ((state == SHIFT) && last_plane && addr_ready));
    assign accept     = s_valid && s_ready;

    always_comb begin
        tap_next[0] = s_data;
        for (int unsigned k = 1; k < TAPS; k++) begin
            tap_next[k] = tap[k-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned k = 0; k < TAPS; k++) tap[k] <= '0;
        end else if (flush) begin
            for (int unsigned k = 0; k < TAPS; k++) tap[k] <= '0;
        end else if (accept) begin
            for (int unsigned k = 0; k < TAPS; k++) tap[k] <= tap_next[k];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            bcnt  <= '0;
            fill  <= '0;
        end else if (flush) begin
            state <= IDLE;
            bcnt  <= '0;
            fill  <= '0;
        end else if (accept) begin
            state <= SHIFT;
            bcnt  <= BW'(DATA_W - 1);
            if (fill != FW'(TAPS)) fill <= fill + 1'b1;
        end else if (plane_hs) begin
            if (last_plane) state <= IDLE;
            else            bcnt  <= bcnt - 1'b1;
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_ser
        da_bit_serializer #(.WIDTH(DATA_W)) u_ser (
            .clk    (clk),
            .resetn (resetn),
            .clr    (flush),
            .load   (accept),
            .shift  (plane_hs && !last_plane),
            .d      (tap_next[k]),
            .msb    (msb[k])
        );
    end

    // Serialisers keep the LSB after the final plane, so gate by state.
    assign addr_valid  = (state == SHIFT);
    assign addr_out    = (state == SHIFT) ? msb : '0;
    assign addr_first  = (state == SHIFT) && (bcnt == BW'(DATA_W - 1));
    assign addr_last   = (state == SHIFT) && last_plane;
    assign window_full = (fill == FW'(TAPS));
    assign busy        = (state == SHIFT);

endmodule

// File: tb/tb_da_tap_window.sv
// Scoreboard bench: a window-level model queues expected bit-planes; a monitor pops them.
module tb_da_tap_window;

    localparam int DW = 16;
    localparam int TP = 64;
    localparam int GR = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          addr_valid;
    logic          addr_ready = 1'b0;
    logic [TP-1:0] addr_out;
    logic          addr_first;
    logic          addr_last;
    logic          window_full;
    logic          busy;

    da_tap_window #(.DATA_W(DW), .TAPS(TP), .GROUP(GR)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .addr_valid  (addr_valid),
        .addr_ready  (addr_ready),
        .addr_out    (addr_out),
        .addr_first  (addr_first),
        .addr_last   (addr_last),
        .window_full (window_full),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TP-1:0] a;
        bit            f;
        bit            l;
    } plane_t;

    plane_t        sb[$];
    logic [DW-1:0] hist[$];
    int            fill = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: compare the presented plane against the queue head, pop on handshake.
    always @(negedge clk) begin
        if (resetn) begin
            check("addr_valid", 64'(addr_valid), 64'(sb.size() != 0));
            check("busy", 64'(busy), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                check("addr_out", 64'(addr_out), 64'(sb[0].a));
                check("addr_first", 64'(addr_first), 64'(sb[0].f));
                check("addr_last", 64'(addr_last), 64'(sb[0].l));
                if (addr_ready) void'(sb.pop_front());
            end else begin
                check("idle_addr_out", 64'(addr_out), 64'd0);
            end
        end
    end

    // Reference model: a window of the newest TP samples becomes DW planes, MSB first.
    always @(negedge clk) begin
        if (resetn) begin
            bit exp_ready;
            plane_t p;
            #1;
            exp_ready = !flush && (sb.size() == 0);
            check("s_ready", 64'(s_ready), 64'(exp_ready));
            check("window_full", 64'(window_full), 64'(fill == TP));
            if (flush) begin
                sb.delete();
                hist.delete();
                fill = 0;
            end else if (s_valid && exp_ready) begin
                hist.push_front(s_data);
                if (hist.size() > TP) void'(hist.pop_back());
                if (fill < TP) fill++;
                for (int b = DW - 1; b >= 0; b--) begin
                    p.a = '0;
                    for (int k = 0; k < hist.size(); k++) p.a[k] = hist[k][b];
                    p.f = (b == DW - 1);
                    p.l = (b == 0);
                    sb.push_back(p);
                end
            end
        end
    end

    task automatic push(input logic [DW-1:0] d);
        bit got = 0;
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (s_ready) got = 1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got no s_ready expected accept within 100 cycles");
        end
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;

        repeat (3) @(posedge clk);
        #1;
        check("reset_s_ready", 64'(s_ready), 64'd1);
        check("reset_addr_valid", 64'(addr_valid), 64'd0);
        check("reset_addr_out", 64'(addr_out), 64'd0);
        check("reset_window_full", 64'(window_full), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        idle_wait(3);

        addr_ready = 1'b1;
        push(16'h8001);
        idle_wait(20);

        push(16'h8001);
        repeat (8) push(16'h0000);
        idle_wait(20);

        // Stall the accumulator for five cycles after plane 8.
        push(DW'($urandom));
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            addr_ready = !(i >= 8 && i < 13);
            @(negedge clk);
            if (busy) cnt++;
            @(posedge clk);
            #1;
        end
        addr_ready = 1'b1;
        check("backpressure_cycles", 64'(cnt), 64'd21);

        push(DW'($urandom));
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        push(16'h0001);
        idle_wait(20);

        flush = 1'b1;
        idle_wait(1);
        flush = 1'b0;
        s_valid = 1'b1;
        cnt = 0;
        for (int t = 0; t < 1300 && cnt < 70; t++) begin
            s_data = DW'($urandom);
            @(negedge clk);
            if (s_ready) cnt++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("stream_accepts", 64'(cnt), 64'd70);
        idle_wait(20);

        for (int t = 0; t < 3000; t++) begin
            s_valid    = ($urandom % 2) == 0;
            s_data     = DW'($urandom);
            addr_ready = ($urandom % 4) != 0;
            flush      = ($urandom % 200) == 0;
            idle_wait(1);
        end
        s_valid    = 1'b0;
        flush      = 1'b0;
        addr_ready = 1'b1;
        idle_wait(20);

        // Asynchronous reset in the middle of a window.
        push(DW'($urandom | 32'h8000));
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_addr_valid", 64'(addr_valid), 64'd0);
        check("async_addr_out", 64'(addr_out), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_addr_first", 64'(addr_first), 64'd0);
        sb.delete();
        hist.delete();
        fill = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle_wait(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
